// File: rtl/adc_8ch_responder_if.sv
// rtl/adc_8ch_responder_if.sv - serial link between ADC/mux master and responder
interface adc_8ch_responder_if;
    logic SCLK;
    logic CS_ADC;
    logic CD_MUX;
    logic DIN;
    logic DOUT;

    modport master (output SCLK, output CS_ADC, output CD_MUX, output DIN, input DOUT);
    modport slave  (input SCLK, input CS_ADC, input CD_MUX, input DIN, output DOUT);
endinterface

// File: rtl/adc_8ch_responder.sv
// rtl/adc_8ch_responder.sv - 8-channel ADC emulator, serial slave side; optional ADC_RESP_PATTERN_EN
module adc_8ch_responder #(
    parameter int DATA_W      = 12,
    parameter int LEAD_BITS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    adc_8ch_responder_if.slave bus,
    input  logic              WR_EN,
    input  logic [2:0]        WR_CH,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic [2:0]        CHANNEL,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR,
    output logic              BUSY
);
    localparam int FRAME_W = DATA_W + LEAD_BITS;
    localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);

    typedef enum logic [2:0] {IDLE, HUNT, CHAN, TAIL, ARMED, SHIFT, DONE} state_t;

    // Synchronizer chain, bit order {SCLK, CS_ADC, CD_MUX, DIN}
    logic [3:0] sync_q [SYNC_STAGES];
    logic       sclk_d;
    logic       mis_q;

    state_t             state, state_n;
    logic [4:0]         bitcnt, bitcnt_n;
    logic [2:0]         ch_sr, ch_sr_n;
    logic [FRAME_W-1:0] frame_sr, frame_sr_n;
    logic               dout_q, dout_n;
    logic               busy_q, busy_n;
    logic [2:0]         channel_q, channel_n;
    logic               err_q, err_n;
    logic [DATA_W-1:0]  table_q [8];
    logic [DATA_W-1:0]  sample_sel;

    logic sclk_s, cs_s, cd_s, din_s;
    logic sclk_rise, sclk_fall, prog, data, mis_now;
    logic [4:0] bitcnt_inc;

    assign {sclk_s, cs_s, cd_s, din_s} = sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_d;
    assign sclk_fall  = ~sclk_s & sclk_d;
    assign prog       = cs_s & cd_s;
    assign data       = ~cs_s & ~cd_s;
    assign mis_now    = cs_s ^ cd_s;
    assign bitcnt_inc = (bitcnt == 5'h1f) ? bitcnt : bitcnt + 5'd1;

    assign bus.DOUT   = dout_q;
    assign CHANNEL    = channel_q;
    assign FRAME_DONE = (state == DONE);
    assign FRAME_ERR  = err_q;
    assign BUSY       = busy_q;

    // Bring the asynchronous serial inputs into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sclk_d <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            sync_q[0] <= {bus.SCLK, bus.CS_ADC, bus.CD_MUX, bus.DIN};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_d <= sclk_s;
            mis_q  <= mis_now;
        end
    end

    // Sample table, writable in every state
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < 8; i++) table_q[i] <= '0;
        end else if (WR_EN) begin
            table_q[WR_CH] <= WR_DATA;
        end
    end

`ifdef ADC_RESP_PATTERN_EN
    logic [8:0] frame_cnt;

    // Completed-frame counter that feeds the test pattern
    always_ff @(posedge clk) begin
        if (!rst_l)          frame_cnt <= '0;
        else if (FRAME_DONE) frame_cnt <= frame_cnt + 9'd1;
    end

    assign sample_sel = {ch_sr, frame_cnt[DATA_W-4:0]};
`else
    assign sample_sel = table_q[ch_sr];
`endif

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state     <= IDLE;
            bitcnt    <= '0;
            ch_sr     <= '0;
            frame_sr  <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            channel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            ch_sr     <= ch_sr_n;
            frame_sr  <= frame_sr_n;
            dout_q    <= dout_n;
            busy_q    <= busy_n;
            channel_q <= channel_n;
            err_q     <= err_n;
        end
    end

    // Next-state logic; phase checks take priority over SCLK edges
    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt;
        ch_sr_n    = ch_sr;
        frame_sr_n = frame_sr;
        dout_n     = dout_q;
        busy_n     = busy_q;
        channel_n  = channel_q;
        err_n      = 1'b0;

        if (state != IDLE && mis_now && mis_q) begin
            state_n = IDLE;
            err_n   = 1'b1;
            dout_n  = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The first rise already carries a DIN bit; a start bit here is not lost
                    if (sclk_rise && prog) begin
                        busy_n   = 1'b1;
                        bitcnt_n = '0;
                        state_n  = din_s ? CHAN : HUNT;
                    end
                end
                HUNT: begin
                    if (!prog) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        dout_n  = 1'b0;
                        busy_n  = 1'b0;
                    end else if (sclk_rise && din_s) begin
                        state_n  = CHAN;
                        bitcnt_n = '0;
                    end
                end
                CHAN: begin
                    if (!prog) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        dout_n  = 1'b0;
                        busy_n  = 1'b0;
                    end else if (sclk_rise) begin
                        ch_sr_n  = {ch_sr[1:0], din_s};
                        bitcnt_n = bitcnt_inc;
                        if (bitcnt == 5'd2) state_n = TAIL;
                    end
                end
                TAIL: begin
                    if (data) begin
                        state_n    = ARMED;
                        channel_n  = ch_sr;
                        frame_sr_n = {{LEAD_BITS{1'b0}}, sample_sel};
                        bitcnt_n   = '0;
                    end
                end
                ARMED, SHIFT: begin
                    if (prog) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        dout_n  = 1'b0;
                        busy_n  = 1'b0;
                    end else if (sclk_rise) begin
                        dout_n     = frame_sr[FRAME_W-1];
                        frame_sr_n = {frame_sr[FRAME_W-2:0], 1'b0};
                        state_n    = SHIFT;
                    end else if (sclk_fall && state == SHIFT) begin
                        if (bitcnt == LAST_BIT) state_n = DONE;
                        else                    bitcnt_n = bitcnt_inc;
                    end
                end
                DONE: begin
                    dout_n  = 1'b0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
